// File: rtl/intersection_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : intersection_phase_scheduler
// Description : Two-approach (NS/EW) traffic phase sequencer with actuated
//               green extension and a latched pedestrian WALK phase.
// Revision    : 1.0 - initial release
// ============================================================================
module intersection_phase_scheduler #(
    parameter int CNT_W     = 8,
    parameter int GREEN_MIN = 10,
    parameter int GREEN_MAX = 30,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_NS_G  = 3'd0,
        S_NS_Y  = 3'd1,
        S_AR_NS = 3'd2,
        S_EW_G  = 3'd3,
        S_EW_Y  = 3'd4,
        S_AR_EW = 3'd5,
        S_WALK  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] c_gmin_m1   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] c_gmax_m1   = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] c_yellow_m1 = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] c_allred_m1 = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] c_walk_m1   = CNT_W'(WALK_T - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_nxt;
    logic             r_next_dir;
    logic             w_ns_conf;
    logic             w_ew_conf;
    logic             w_green;
    logic             w_enter_walk;

    always_comb begin
        w_next    = r_state;
        w_ns_conf = ew_req | ped_pending;
        w_ew_conf = ns_req | ped_pending;
        case (r_state)
            S_NS_G:  if (tick && w_ns_conf &&
                         ((r_timer >= c_gmin_m1 && !ns_req) || r_timer >= c_gmax_m1))
                         w_next = S_NS_Y;
            S_NS_Y:  if (tick && r_timer == c_yellow_m1) w_next = S_AR_NS;
            S_AR_NS: if (tick && r_timer == c_allred_m1)
                         w_next = ped_pending ? S_WALK : S_EW_G;
            S_EW_G:  if (tick && w_ew_conf &&
                         ((r_timer >= c_gmin_m1 && !ew_req) || r_timer >= c_gmax_m1))
                         w_next = S_EW_Y;
            S_EW_Y:  if (tick && r_timer == c_yellow_m1) w_next = S_AR_EW;
            S_AR_EW: if (tick && r_timer == c_allred_m1)
                         w_next = ped_pending ? S_WALK : S_NS_G;
            S_WALK:  if (tick && r_timer == c_walk_m1)
                         w_next = r_next_dir ? S_EW_G : S_NS_G;
            default: w_next = S_AR_EW;  // illegal code recovers without waiting for tick
        endcase
    end

    // Green timer saturates so an indefinitely resting green cannot wrap
    always_comb begin
        w_green      = (r_state == S_NS_G) || (r_state == S_EW_G);
        w_enter_walk = (w_next == S_WALK) && (r_state != S_WALK);
        w_timer_nxt  = r_timer;
        if (w_next != r_state)
            w_timer_nxt = '0;
        else if (tick && !(w_green && r_timer >= c_gmax_m1))
            w_timer_nxt = r_timer + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_AR_EW;
            r_timer    <= '0;
            r_next_dir <= 1'b0;
        end else begin
            r_state <= w_next;
            r_timer <= w_timer_nxt;
            if (w_enter_walk)
                r_next_dir <= (r_state == S_AR_NS);
        end
    end

    // A new press on the entry edge wins over the clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ped_pending <= 1'b0;
        else if (ped_req)
            ped_pending <= 1'b1;
        else if (w_enter_walk)
            ped_pending <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ns_red    <= 1'b1;
            ns_yellow <= 1'b0;
            ns_green  <= 1'b0;
            ew_red    <= 1'b1;
            ew_yellow <= 1'b0;
            ew_green  <= 1'b0;
            walk      <= 1'b0;
            phase     <= 3'd5;
        end else begin
            ns_green  <= (w_next == S_NS_G);
            ns_yellow <= (w_next == S_NS_Y);
            ns_red    <= (w_next != S_NS_G) && (w_next != S_NS_Y);
            ew_green  <= (w_next == S_EW_G);
            ew_yellow <= (w_next == S_EW_Y);
            ew_red    <= (w_next != S_EW_G) && (w_next != S_EW_Y);
            walk      <= (w_next == S_WALK);
            phase     <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_intersection_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_intersection_phase_scheduler
// Description : Table, directed and random checks against a phase-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intersection_phase_scheduler;

    localparam int GMIN = 10;
    localparam int GMAX = 30;
    localparam int YEL  = 3;
    localparam int AR   = 2;
    localparam int WLK  = 8;

    logic       clk = 1'b0;
    logic       reset, tick, ns_req, ew_req, ped_req;
    logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
    logic       walk, ped_pending;
    logic [2:0] phase;

    always #5 clk = ~clk;

    intersection_phase_scheduler dut (
        .clk(clk), .reset(reset), .tick(tick), .ns_req(ns_req), .ew_req(ew_req),
        .ped_req(ped_req), .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green), .walk(walk),
        .ped_pending(ped_pending), .phase(phase)
    );

    int checks = 0;
    int errors = 0;

    // Phase-level model: phase number, ticks spent in the phase, pedestrian latch, WALK target
    int m_phase;
    int m_el;
    bit m_ped;
    bit m_dir;

    typedef struct {
        bit tk; bit ns; bit ew; bit pd;
        int exp_phase; bit exp_ped;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dur(input int ph);
        case (ph)
            1, 4:    return YEL;
            2, 5:    return AR;
            default: return WLK;
        endcase
    endfunction

    function automatic logic [9:0] exp_vec();
        logic [9:0] v;
        v[9:7] = 3'(m_phase);
        v[6]   = !(m_phase == 0 || m_phase == 1);
        v[5]   = (m_phase == 1);
        v[4]   = (m_phase == 0);
        v[3]   = !(m_phase == 3 || m_phase == 4);
        v[2]   = (m_phase == 4);
        v[1]   = (m_phase == 3);
        v[0]   = (m_phase == 6);
        return {v[9:1], v[0]};
    endfunction

    function automatic logic [10:0] exp_all();
        return {exp_vec(), m_ped};
    endfunction

    function automatic logic [10:0] act_all();
        return {phase, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_pending};
    endfunction

    task automatic model_reset();
        m_phase = 5; m_el = 0; m_ped = 0; m_dir = 0;
    endtask

    task automatic model_step(input bit t, input bit n, input bit e, input bit p);
        int nxt;
        bit own, conf;
        nxt = m_phase;
        if (t) begin
            if (m_phase == 0 || m_phase == 3) begin
                own  = (m_phase == 0) ? n : e;
                conf = ((m_phase == 0) ? e : n) | m_ped;
                if (conf && ((m_el >= GMIN - 1 && !own) || m_el >= GMAX - 1))
                    nxt = m_phase + 1;
            end else if (m_el == dur(m_phase) - 1) begin
                case (m_phase)
                    1:       nxt = 2;
                    4:       nxt = 5;
                    2:       nxt = m_ped ? 6 : 3;
                    5:       nxt = m_ped ? 6 : 0;
                    default: nxt = m_dir ? 3 : 0;
                endcase
            end
        end
        if (nxt == 6 && m_phase != 6) m_dir = (m_phase == 2);
        if (p) m_ped = 1;
        else if (nxt == 6 && m_phase != 6) m_ped = 0;
        if (nxt != m_phase) m_el = 0;
        else if (t) m_el++;
        m_phase = nxt;
    endtask

    task automatic cycle(input bit t, input bit n, input bit e, input bit p);
        tick = t; ns_req = n; ew_req = e; ped_req = p;
        @(posedge clk);
        model_step(t, n, e, p);
        #1;
        chk("outputs", 16'(act_all()), 16'(exp_all()));
    endtask

    // Asynchronous: outputs must show the reset state before any clock edge
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_reset", 16'(act_all()), 16'(exp_all()));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_to(input int ph, input bit n, input bit e, input int limit, output int cnt);
        cnt = 0;
        while (int'(phase) != ph && cnt < limit) begin
            cycle(1'b1, n, e, 1'b0);
            cnt++;
        end
        chk("reach_phase", 16'(phase), 16'(ph));
    endtask

    initial begin
        int n, total;
        logic [10:0] snap;
        bit rn, re;
        reset = 1'b1; tick = 0; ns_req = 0; ew_req = 0; ped_req = 0;
        model_reset();
        #12;
        chk("reset_state", 16'(act_all()), 16'({3'd5, 7'b1001000, 1'b0}));
        reset = 1'b0;

        tbl[0] = '{1, 0, 0, 0, 5, 0};
        tbl[1] = '{1, 0, 0, 0, 0, 0};
        tbl[2] = '{0, 0, 0, 1, 0, 1};
        tbl[3] = '{0, 0, 0, 0, 0, 1};
        tbl[4] = '{1, 1, 0, 0, 0, 1};
        tbl[5] = '{1, 1, 0, 0, 0, 1};
        tbl[6] = '{1, 0, 0, 1, 0, 1};
        tbl[7] = '{0, 0, 1, 0, 0, 1};
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].tk, tbl[i].ns, tbl[i].ew, tbl[i].pd);
            chk("tbl_phase", 16'(phase), 16'(tbl[i].exp_phase));
            chk("tbl_ped", 16'(ped_pending), 16'(tbl[i].exp_ped));
        end

        // No demand: NS green rests indefinitely
        do_reset();
        run_to(0, 0, 0, 10, n);
        chk("ar_ew_to_ns_g", 16'(n), 16'(2));
        for (int i = 0; i < 120; i++) cycle(1, 0, 0, 0);
        chk("rest_ns_green", 16'(ns_green), 16'(1));

        // Minimum green with gap-out, then clearance to EW
        do_reset();
        run_to(0, 0, 0, 10, n);
        run_to(1, 0, 1, 60, n); chk("ns_g_min", 16'(n), 16'(GMIN));
        run_to(2, 0, 1, 10, n); chk("ns_y_len", 16'(n), 16'(YEL));
        run_to(3, 0, 1, 10, n); chk("ar_ns_len", 16'(n), 16'(AR));
        chk("ew_green_on", 16'(ew_green), 16'(1));

        // Continuous demand both ways: max-out cycle of 70 ticks
        run_to(5, 1, 1, 100, n);
        run_to(0, 1, 1, 10, n);
        total = 0;
        run_to(1, 1, 1, 60, n); chk("ns_g_max", 16'(n), 16'(GMAX)); total += n;
        run_to(2, 1, 1, 10, n); total += n;
        run_to(3, 1, 1, 10, n); total += n;
        run_to(4, 1, 1, 60, n); chk("ew_g_max", 16'(n), 16'(GMAX)); total += n;
        run_to(5, 1, 1, 10, n); total += n;
        run_to(0, 1, 1, 10, n); total += n;
        chk("cycle_period", 16'(total), 16'(70));

        // Pedestrian pulse in NS green with no vehicle demand
        cycle(0, 0, 0, 1);
        chk("ped_latched", 16'(ped_pending), 16'(1));
        run_to(1, 0, 0, 60, n); chk("ped_ns_g_len", 16'(n), 16'(GMIN));
        run_to(2, 0, 0, 10, n);
        run_to(6, 0, 0, 10, n); chk("walk_entry", 16'(n), 16'(AR));
        chk("walk_lamp", 16'({walk, ped_pending, ns_red, ew_red}), 16'(4'b1011));
        run_to(3, 0, 0, 20, n); chk("walk_len", 16'(n), 16'(WLK));

        // Tick gated off in NS yellow: everything frozen except the ped latch
        run_to(0, 1, 0, 60, n);
        run_to(1, 0, 1, 60, n);
        snap = act_all();
        for (int i = 0; i < 50; i++) cycle(0, 0, 1, i == 20);
        chk("freeze_lamps", 16'(act_all() >> 1), 16'(snap >> 1));
        chk("freeze_ped", 16'(ped_pending), 16'(1));
        run_to(2, 0, 1, 10, n); chk("ns_y_after_freeze", 16'(n), 16'(YEL));

        // Reset mid EW green
        run_to(3, 0, 1, 60, n);
        cycle(1, 0, 1, 1);
        do_reset();
        run_to(0, 0, 0, 10, n);
        chk("post_reset_ns_g", 16'(n), 16'(2));

        // Random traffic against the model
        rn = 0; re = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 19) == 0) rn = !rn;
            if ($urandom_range(0, 19) == 0) re = !re;
            if ($urandom_range(0, 1999) == 0) do_reset();
            else cycle($urandom_range(0, 2) != 0, rn, re, $urandom_range(0, 99) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
